gcd_datapath: RTL and testbench

GCD_DATAPATH -- requirements
Module: gcd_datapath

---
 rtl/gcd_datapath.sv | 86 ++++++++
 tb/tb_gcd_datapath.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_datapath.sv
// Subtractive GCD datapath: X/Y operand registers with difference muxes, G result register,
// status flags. Optional iteration counter and iter port under macro GCD_ITER_CNT_EN.
module gcd_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             xmsel,
    input  logic             ymsel,
    input  logic             xld,
    input  logic             yld,
    input  logic             gld,
    input  logic [WIDTH-1:0] xin,
    input  logic [WIDTH-1:0] yin,
    output logic             eqflg,
    output logic             itflg,
    output logic [WIDTH-1:0] gcd,
    output logic             gvld,
    output logic             err
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [15:0]      iter
`endif
);

    localparam int unsigned ITER_W = 16;

    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] x_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic             x_sub;
    logic             y_sub;
    logic             op_load;
    logic             err_set;

    // Comparator flags straight from the operand registers
    assign eqflg = (x_q == y_q);
    assign itflg = (x_q < y_q);

    // Load muxes, classification of load types and error detection
    always_comb begin
        x_sub   = xld & ~xmsel;
        y_sub   = yld & ~ymsel;
        op_load = (xld & xmsel) | (yld & ymsel);
        x_nxt   = xmsel ? xin : WIDTH'(x_q - y_q);
        y_nxt   = ymsel ? yin : WIDTH'(y_q - x_q);
        err_set = (x_sub & y_sub)
                | (x_sub & (x_q < y_q))
                | (y_sub & (y_q < x_q))
                | (xld & xmsel & (xin == '0))
                | (yld & ymsel & (yin == '0));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            x_q  <= '0;
            y_q  <= '0;
            gcd  <= '0;
            gvld <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (xld) x_q <= x_nxt;
            if (yld) y_q <= y_nxt;
            if (gld) gcd <= x_q;
            // A fresh operand invalidates any earlier result, even alongside gld
            if (op_load)  gvld <= 1'b0;
            else if (gld) gvld <= 1'b1;
            if (err_set) err <= 1'b1;
        end
    end

`ifdef GCD_ITER_CNT_EN
    // Counts subtract steps since the last operand load, saturating
    always_ff @(posedge clk) begin
        if (clr) begin
            iter <= '0;
        end else if (op_load) begin
            iter <= '0;
        end else if ((x_sub | y_sub) && (iter != {ITER_W{1'b1}})) begin
            iter <= ITER_W'(iter + 16'd1);
        end
    end
`endif

endmodule

// File: tb/tb_gcd_datapath.sv
// Scoreboard bench for gcd_datapath: a reference model pushes expected post-edge state per
// driven cycle; it is popped and compared after the edge. Honors GCD_ITER_CNT_EN.
module tb_gcd_datapath;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             clr, xmsel, ymsel, xld, yld, gld;
    logic [WIDTH-1:0] xin, yin;
    logic             eqflg, itflg, gvld, err;
    logic [WIDTH-1:0] gcd;
`ifdef GCD_ITER_CNT_EN
    logic [15:0]      iter;
`endif

    gcd_datapath #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clr   (clr),
        .xmsel (xmsel),
        .ymsel (ymsel),
        .xld   (xld),
        .yld   (yld),
        .gld   (gld),
        .xin   (xin),
        .yin   (yin),
        .eqflg (eqflg),
        .itflg (itflg),
        .gcd   (gcd),
        .gvld  (gvld),
        .err   (err)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter  (iter)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] gcd;
        logic             gvld;
        logic             err;
        logic             eq;
        logic             lt;
        logic [15:0]      iter;
    } exp_t;

    exp_t q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [WIDTH-1:0] mx = '0, my = '0, mg = '0;
    logic             mgv = 1'b0, merr = 1'b0;
    logic [15:0]      mit = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Drive one cycle, advance the model, then compare DUT against the popped expectation
    task automatic step(input logic c, input logic xl, input logic xm, input logic yl,
                        input logic ym, input logic gl, input logic [WIDTH-1:0] xi,
                        input logic [WIDTH-1:0] yi);
        logic [WIDTH-1:0] nx, ny;
        logic xs, ys, opl;
        exp_t e;
        clr = c; xld = xl; xmsel = xm; yld = yl; ymsel = ym; gld = gl; xin = xi; yin = yi;
        if (c) begin
            mx = '0; my = '0; mg = '0; mgv = 1'b0; merr = 1'b0; mit = '0;
        end else begin
            xs  = xl & ~xm;
            ys  = yl & ~ym;
            opl = (xl & xm) | (yl & ym);
            if ((xs && ys) || (xs && mx < my) || (ys && my < mx) ||
                (xl && xm && xi == 0) || (yl && ym && yi == 0))
                merr = 1'b1;
            nx = xl ? (xm ? xi : WIDTH'(mx - my)) : mx;
            ny = yl ? (ym ? yi : WIDTH'(my - mx)) : my;
            if (gl) mg = mx;
            if (opl) mgv = 1'b0;
            else if (gl) mgv = 1'b1;
            if (opl) mit = '0;
            else if ((xs || ys) && mit != 16'hFFFF) mit = mit + 16'd1;
            mx = nx; my = ny;
        end
        e.gcd = mg; e.gvld = mgv; e.err = merr; e.eq = (mx == my); e.lt = (mx < my);
        e.iter = mit;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("gcd",   32'(gcd),   32'(e.gcd));
        check("gvld",  32'(gvld),  32'(e.gvld));
        check("err",   32'(err),   32'(e.err));
        check("eqflg", 32'(eqflg), 32'(e.eq));
        check("itflg", 32'(itflg), 32'(e.lt));
`ifdef GCD_ITER_CNT_EN
        check("iter",  32'(iter),  32'(e.iter));
`endif
    endtask

    task automatic do_reset();                         step(1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
                                                       step(0, 1, 1, 1, 1, 0, a, b); endtask
    task automatic xsub();                             step(0, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic ysub();                             step(0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic gload();                            step(0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic idle();                             step(0, 0, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        int unsigned a, b, k;
        clr = 1'b1; xmsel = 0; ymsel = 0; xld = 0; yld = 0; gld = 0; xin = '0; yin = '0;

        // Reset state
        do_reset();
        check("rst_eq",   32'(eqflg), 32'd1);
        check("rst_lt",   32'(itflg), 32'd0);
        check("rst_gvld", 32'(gvld),  32'd0);
        check("rst_err",  32'(err),   32'd0);

        // 12,18 walk-through
        load(12, 18);
        check("lt_12_18", 32'(itflg), 32'd1);
        ysub();
        check("lt_12_6", 32'(itflg), 32'd0);
        xsub();
        check("eq_6_6", 32'(eqflg), 32'd1);
        gload();
        check("gcd_6",  32'(gcd),  32'd6);
        check("gvld_6", 32'(gvld), 32'd1);
        check("err_6",  32'(err),  32'd0);
`ifdef GCD_ITER_CNT_EN
        check("iter_6", 32'(iter), 32'd2);
`endif

        // Equal operands
        load(7, 7);
        check("eq_7",      32'(eqflg), 32'd1);
        check("gvld_clr7", 32'(gvld),  32'd0);
        gload();
        check("gcd_7", 32'(gcd), 32'd7);
`ifdef GCD_ITER_CNT_EN
        check("iter_7", 32'(iter), 32'd0);
`endif

        // Operand load drops gvld while G holds; mux selects ignored without load enable
        load(20, 8);
        check("gvld_drop", 32'(gvld), 32'd0);
        check("gcd_hold",  32'(gcd),  32'd7);
        step(0, 0, 1, 0, 1, 0, 8'hAA, 8'h55);
        while (mx != my) begin
            if (mx < my) ysub(); else xsub();
        end
        gload();
        gload();
        check("gcd_4",    32'(gcd),  32'd4);
        check("gvld_rep", 32'(gvld), 32'd1);

        // Underflow on X subtract: wrap, sticky error
        do_reset();
        load(5, 9);
        xsub();
        check("err_lt", 32'(err), 32'd1);
        gload();
        check("gcd_252", 32'(gcd), 32'd252);
        idle();
        load(3, 3);
        check("err_sticky", 32'(err), 32'd1);
        do_reset();
        check("err_clr", 32'(err), 32'd0);

        // Simultaneous subtracts, then a zero operand
        load(9, 9);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("err_both", 32'(err), 32'd1);
        do_reset();
        load(0, 3);
        check("err_zero", 32'(err), 32'd1);

        // Reset in the middle of a subtract cycle
        do_reset();
        load(12, 18);
        ysub();
        gload();
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check("mid_gcd",  32'(gcd),   32'd0);
        check("mid_gvld", 32'(gvld),  32'd0);
        check("mid_err",  32'(err),   32'd0);
        check("mid_eq",   32'(eqflg), 32'd1);
`ifdef GCD_ITER_CNT_EN
        check("mid_iter", 32'(iter), 32'd0);
`endif

        // Random operand pairs run to completion
        for (int r = 0; r < 6; r++) begin
            a = $urandom_range(1, 255);
            b = $urandom_range(1, 255);
            load(WIDTH'(a), WIDTH'(b));
            k = 0;
            while (mx != my && k < 600) begin
                if (mx < my) ysub(); else xsub();
                k++;
            end
            gload();
            check("rand_gcd", 32'(gcd), ref_gcd(a, b));
            check("rand_err", 32'(err), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
